// File: rtl/burst_arbiter_if.sv
// Request/grant bundle between requesters (master) and burst_arbiter (slave).
interface burst_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  localparam int ID_W = (NUM_PORTS == 1) ? 1 : $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] req_last;
  logic                 out_ready;
  logic [NUM_PORTS-1:0] gnt;
  logic [ID_W-1:0]      gnt_id;
  logic                 out_valid;
  logic                 busy;

  modport master (
    output req, req_last, out_ready,
    input  gnt, gnt_id, out_valid, busy
  );

  modport slave (
    input  req, req_last, out_ready,
    output gnt, gnt_id, out_valid, busy
  );
endinterface

// File: rtl/burst_arbiter.sv
// Round-robin burst arbiter: a winner holds the grant until its last beat.
// Optional macro BURST_LIMIT_EN caps each grant at MAX_BURST beats.
module burst_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BURST = 8
) (
  input  logic            clk,
  input  logic            rst,
  burst_arbiter_if.slave  bus
);
  localparam int ID_W = (NUM_PORTS == 1) ? 1 : $clog2(NUM_PORTS);

  if (NUM_PORTS < 1 || NUM_PORTS > 16 || MAX_BURST < 1 || MAX_BURST > 256) begin : g_bad_cfg
    $error("burst_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] prev_q, prev_d;
  logic [ID_W-1:0] winner;
  logic            owner_req;
  logic            owner_last;
  logic            beat;
  logic            limit_hit;

  // First requester strictly after the previous owner, wrapping around.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_PORTS-1:0] r,
                                              input logic [ID_W-1:0]      p);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(p) + i) % NUM_PORTS;
      if (!found && r[idx]) begin
        pick  = ID_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner     = rr_pick(bus.req, prev_q);
  assign owner_req  = bus.req[owner_q];
  assign owner_last = bus.req_last[owner_q];
  assign beat       = bus.out_valid && bus.out_ready;

  assign bus.busy      = (state_q == LOCKED);
  assign bus.gnt       = (state_q == LOCKED) ? (NUM_PORTS'(1) << owner_q) : '0;
  assign bus.gnt_id    = owner_q;
  assign bus.out_valid = (state_q == LOCKED) && owner_req;

`ifdef BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign limit_hit = beat && (cnt_q == CNT_W'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      if (|bus.req) cnt_d = '0;
    end else if (beat && (cnt_q != CNT_W'(MAX_BURST))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prev_d  = prev_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = winner;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        // Release demotes the owner to lowest priority for the next round.
        if (beat && (owner_last || limit_hit)) begin
          state_d = IDLE;
          prev_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      prev_q  <= ID_W'(NUM_PORTS - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prev_q  <= prev_d;
    end
  end
endmodule

// File: tb/tb_burst_arbiter.sv
// Scoreboard bench for burst_arbiter (4-port instance plus a 1-port instance).
module tb_burst_arbiter;
  localparam int  MAXB = 8;
`ifdef BURST_LIMIT_EN
  localparam bit  LIM  = 1'b1;
`else
  localparam bit  LIM  = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] id;
    logic       ov;
    logic       busy;
  } exp_t;

  logic clk;
  logic rst;

  burst_arbiter_if #(.NUM_PORTS(4)) bus  ();
  burst_arbiter_if #(.NUM_PORTS(1)) bus1 ();

  burst_arbiter #(.NUM_PORTS(4), .MAX_BURST(MAXB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  burst_arbiter #(.NUM_PORTS(1), .MAX_BURST(MAXB)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t expq[$];
  int   gq[$];
  int   q1[$];
  bit   prev_busy = 1'b0;

  // reference model state
  bit   m_locked = 1'b0;
  int   m_owner  = 0;
  int   m_prev   = 3;
  int   m_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked  = 1'b0;
    m_owner   = 0;
    m_prev    = 3;
    m_cnt     = 0;
    prev_busy = 1'b0;
  endtask

  // One clock period, entered and left at the falling edge.
  task automatic cycle(input logic [3:0] r, input logic [3:0] l, input logic rdy, input logic r1);
    exp_t e;
    exp_t g;
    bit   found;
    int   p;
    bus.req        = r;
    bus.req_last   = l;
    bus.out_ready  = rdy;
    bus1.req       = r1;
    bus1.req_last  = 1'b1;
    bus1.out_ready = 1'b1;
    #1;
    if (!rst) begin
      model_reset();
      e = '0;
    end else begin
      e.gnt  = m_locked ? (4'b0001 << m_owner) : 4'b0000;
      e.id   = 2'(m_owner);
      e.ov   = m_locked && r[m_owner];
      e.busy = m_locked;
    end
    expq.push_back(e);

    g = expq.pop_front();
    chk("gnt",       32'(bus.gnt),       32'(g.gnt));
    chk("gnt_id",    32'(bus.gnt_id),    32'(g.id));
    chk("out_valid", 32'(bus.out_valid), 32'(g.ov));
    chk("busy",      32'(bus.busy),      32'(g.busy));

    if (bus.busy && !prev_busy) begin
      if (gq.size() == 0) chk("grant_extra", 32'(bus.gnt_id), 32'hff);
      else                chk("grant_order", 32'(bus.gnt_id), 32'(gq.pop_front()));
    end
    prev_busy = bus.busy;

    if (q1.size() != 0) begin
      p = q1.pop_front();
      chk("p1_busy",   32'(bus1.busy),      32'(p));
      chk("p1_gnt",    32'(bus1.gnt),       32'(p));
      chk("p1_gnt_id", 32'(bus1.gnt_id),    32'd0);
      chk("p1_valid",  32'(bus1.out_valid), 32'(p));
    end

    if (rst) begin
      if (!m_locked) begin
        if (r != 4'b0000) begin
          found = 1'b0;
          for (int k = 1; k <= 4; k++) begin
            p = (m_prev + k) % 4;
            if (!found && r[p]) begin
              m_owner = p;
              found   = 1'b1;
            end
          end
          m_locked = 1'b1;
          m_cnt    = 0;
        end
      end else if (r[m_owner] && rdy) begin
        if (m_cnt < MAXB) m_cnt++;
        if (l[m_owner] || (LIM && m_cnt == MAXB)) begin
          m_locked = 1'b0;
          m_prev   = m_owner;
        end
      end
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b0;
    bus.req        = '0;
    bus.req_last   = '0;
    bus.out_ready  = 1'b0;
    bus1.req       = 1'b0;
    bus1.req_last  = 1'b0;
    bus1.out_ready = 1'b0;
    @(negedge clk);

    // reset state with requests pending
    cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
    rst = 1'b1;

    // all ports request single-beat bursts: 0,1,2,3,0
    gq.push_back(0); gq.push_back(1); gq.push_back(2); gq.push_back(3); gq.push_back(0);
    for (int i = 0; i < 10; i++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // port 2, three beats with a stall on beat 2
    gq.push_back(2);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0100, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 4'b0100, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // port 1 drops req mid-burst while port 3 waits
    gq.push_back(1); gq.push_back(3);
    cycle(4'b0010, 4'b0000, 1'b1, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    cycle(4'b1000, 4'b0000, 1'b1, 1'b0);
    cycle(4'b1010, 4'b0010, 1'b1, 1'b0);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // port 0 streams without last
    gq.push_back(0);
`ifdef BURST_LIMIT_EN
    gq.push_back(1); gq.push_back(0);
`endif
    for (int i = 0; i < 20; i++) cycle(4'b0011, 4'b0000, 1'b1, 1'b0);
    cycle(4'b0011, 4'b0011, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // asynchronous reset mid-burst
    gq.push_back(0); gq.push_back(3);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_gnt",    32'(bus.gnt),       32'd0);
    chk("rst_busy",   32'(bus.busy),      32'd0);
    chk("rst_valid",  32'(bus.out_valid), 32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id),    32'd0);
    model_reset();
    @(negedge clk);
    cycle(4'b0001, 4'b0001, 1'b1, 1'b0);
    rst = 1'b1;
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
    cycle(4'b1000, 4'b1000, 1'b1, 1'b0);
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    // single-port instance: grant alternates with idle cycles
    for (int i = 0; i < 6; i++) begin
      q1.push_back(i % 2);
      cycle(4'b0000, 4'b0000, 1'b1, 1'b1);
    end
    cycle(4'b0000, 4'b0000, 1'b1, 1'b0);

    if (gq.size() != 0) chk("grant_missing", 32'(gq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
